// File: rtl/onchip_mem_dp_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_dp_if
// One Avalon-MM slave port of the dual-port on-chip RAM.
//
// Signals:
//   address        word address (ADDR_WIDTH)
//   byteenable     per-byte write lane enables (DATA_WIDTH/8)
//   chipselect     port select
//   read / write   request strobes
//   writedata      write data (DATA_WIDTH)
//   readdata       read data, meaningful only with readdatavalid
//   readdatavalid  read-data strobe
//   waitrequest    stall; a request is taken only when this is 0
//
// Modports: master drives requests, slave drives responses.
// ---------------------------------------------------------------------------
interface onchip_mem_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_mem_dp.sv
// ---------------------------------------------------------------------------
// onchip_mem_dp
// True-dual-port on-chip RAM with two independent Avalon-MM slave ports,
// byte enables, a 1- or 2-cycle read pipeline with readdatavalid and an
// optional hardware clear sequence after reset.
//
// Ports:
//   clk         single clock, rising edge
//   reset_n     asynchronous active-low reset
//   clken       global clock enable; 0 freezes all state
//   s1, s2      Avalon-MM slave ports (onchip_mem_dp_if.slave)
//   clear_busy  high while the post-reset clear sequence runs
// ---------------------------------------------------------------------------
module onchip_mem_dp #(
  parameter int                      DATA_WIDTH     = 32,
  parameter int                      DEPTH          = 5120,
  parameter int                      ADDR_WIDTH     = 13,
  parameter int                      READ_LATENCY   = 1,
  parameter int                      CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  onchip_mem_dp_if.slave  s1,
  onchip_mem_dp_if.slave  s2,
  output logic            clear_busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clear_we;
  logic                  waitreq;

  // Per-port request/response signals, index 0 = s1, index 1 = s2.
  logic [1:0][ADDR_WIDTH-1:0] addr;
  logic [1:0][NB-1:0]         be;
  logic [1:0]                 cs, rd_req, wr_req;
  logic [1:0][DATA_WIDTH-1:0] wdata;
  logic [1:0]                 in_range, acc, wr_en, rd_acc, rd_en;
  logic [1:0][DATA_WIDTH-1:0] ram_rd;
  logic [1:0][DATA_WIDTH-1:0] rdata;
  logic [1:0]                 rvalid;

  assign addr[0]   = s1.address;
  assign addr[1]   = s2.address;
  assign be[0]     = s1.byteenable;
  assign be[1]     = s2.byteenable;
  assign cs[0]     = s1.chipselect;
  assign cs[1]     = s2.chipselect;
  assign rd_req[0] = s1.read;
  assign rd_req[1] = s2.read;
  assign wr_req[0] = s1.write;
  assign wr_req[1] = s2.write;
  assign wdata[0]  = s1.writedata;
  assign wdata[1]  = s2.writedata;

  assign s1.readdata      = rdata[0];
  assign s2.readdata      = rdata[1];
  assign s1.readdatavalid = rvalid[0];
  assign s2.readdatavalid = rvalid[1];
  assign s1.waitrequest   = waitreq;
  assign s2.waitrequest   = waitreq;

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clken && state_q == ST_CLEAR) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign clear_we   = (state_q == ST_CLEAR) & clken & reset_n;

  // Stall during reset, during the clear and whenever the clock is gated;
  // the RAM has no other source of back-pressure.
  assign waitreq = ~reset_n | (state_q == ST_CLEAR) | ~clken;

  // ---------------------------------------------------------------------
  // Per-port request decode and read pipeline
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  v1_q;
    logic                  ok1_q;
    logic [DATA_WIDTH-1:0] st1_data;

    // Widen before comparing so a power-of-two DEPTH does not overflow.
    assign in_range[gi] = {1'b0, addr[gi]} < DEPTH_W;
    assign acc[gi]      = cs[gi] & (rd_req[gi] | wr_req[gi]) & ~waitreq;
    assign wr_en[gi]    = acc[gi] & wr_req[gi] & in_range[gi];
    // A simultaneous read+write is treated as a write only.
    assign rd_acc[gi]   = acc[gi] & rd_req[gi] & ~wr_req[gi];
    assign rd_en[gi]    = rd_acc[gi] & in_range[gi];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v1_q  <= 1'b0;
        ok1_q <= 1'b0;
      end else if (clken) begin
        v1_q <= rd_acc[gi];
        if (rd_acc[gi]) begin
          ok1_q <= in_range[gi];
        end
      end
    end

    // Out-of-range reads never touch the RAM; masking here returns zero
    // and also keeps the un-reset RAM output register invisible after reset.
    assign st1_data = ok1_q ? ram_rd[gi] : '0;

    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2_q;
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v2_q   <= 1'b0;
          dout_q <= '0;
        end else if (clken) begin
          v2_q <= v1_q;
          if (v1_q) begin
            dout_q <= st1_data;
          end
        end
      end

      assign rdata[gi]  = dout_q;
      assign rvalid[gi] = v2_q & clken;
    end else begin : g_lat1
      assign rdata[gi]  = st1_data;
      assign rvalid[gi] = v1_q & clken;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one byte-wide true-dual-port array per lane.
  // s2 is written before s1 so that on an address collision the later
  // non-blocking assignment from s1 wins for lanes it enables. Reads use
  // the pre-edge contents, giving old data on read-during-write.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_byte_q [2];

    always_ff @(posedge clk) begin
      if (clear_we) begin
        mem_q[cnt_q] <= CLEAR_VALUE[gi*8 +: 8];
      end
      if (wr_en[1] && be[1][gi]) begin
        mem_q[addr[1]] <= wdata[1][gi*8 +: 8];
      end
      if (wr_en[0] && be[0][gi]) begin
        mem_q[addr[0]] <= wdata[0][gi*8 +: 8];
      end
      if (rd_en[0]) begin
        rd_byte_q[0] <= mem_q[addr[0]];
      end
      if (rd_en[1]) begin
        rd_byte_q[1] <= mem_q[addr[1]];
      end
    end

    assign ram_rd[0][gi*8 +: 8] = rd_byte_q[0];
    assign ram_rd[1][gi*8 +: 8] = rd_byte_q[1];
  end

endmodule
